// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared op encodings, FSM states and constants for muldiv_unit
// Revision: 1.0
// ============================================================================
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [31:0] C_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] C_ALL_ONES = 32'hFFFF_FFFF;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_if
// Brief   : Start/busy/valid request and result bundle for muldiv_unit
// Revision: 1.0
// ============================================================================
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        kill;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  modport master (
    output start, op, rs1_val, rs2_val, rd_in, kill,
    input  busy, valid, result, rd_out
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_in, kill,
    output busy, valid, result, rd_out
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_step
// Brief   : One combinational iteration: shift-add multiply or restoring divide
// Revision: 1.0
// ============================================================================
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        mode,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] opnd,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next
);

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;

  // Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    w_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
    w_shift = {hi, lo[31]};
    w_ge    = (w_shift >= {1'b0, opnd});
    w_diff  = w_shift[31:0] - opnd;
    if (mode == MODE_DIV) begin
      hi_next = w_ge ? w_diff : w_shift[31:0];
      lo_next = {lo[30:0], w_ge};
    end else begin
      hi_next = w_sum[32:1];
      lo_next = {w_sum[0], lo[31:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative RV32M multiply/divide, fixed 34-cycle latency
// Revision: 1.0
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     CLK,
  input  logic     rst,
  muldiv_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic              w_busy;
  logic              w_valid;
  logic              w_accept;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic [31:0]       r_opnd;
  logic [31:0]       r_a_raw;
  logic [63:0]       r_acc;
  logic              r_sign_a;
  logic              r_sign_b;
  logic              r_div_zero;
  logic              r_div_ovf;
  logic [31:0]       r_result;
  logic [4:0]        r_rd_out;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [31:0]       w_a_mag;
  logic [31:0]       w_b_mag;
  logic [31:0]       w_hi_next;
  logic [31:0]       w_lo_next;
  logic [63:0]       w_prod;
  logic [31:0]       w_quo;
  logic [31:0]       w_rem;
  logic [31:0]       w_fix;

  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start && !bus.kill;

  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_CALC;
      end
      ST_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) w_next = ST_FIX;
      end
      ST_FIX: begin
        w_busy = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_valid = 1'b1;
        w_next  = w_accept ? ST_CALC : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (bus.kill) w_next = ST_IDLE;
  end

  assign bus.busy   = w_busy;
  assign bus.valid  = w_valid;
  assign bus.result = r_result;
  assign bus.rd_out = r_rd_out;

  // Magnitudes only for operands the op treats as signed
  assign w_a_neg = op_a_signed(bus.op) & bus.rs1_val[31];
  assign w_b_neg = op_b_signed(bus.op) & bus.rs2_val[31];
  assign w_a_mag = w_a_neg ? (~bus.rs1_val + 32'd1) : bus.rs1_val;
  assign w_b_mag = w_b_neg ? (~bus.rs2_val + 32'd1) : bus.rs2_val;

  muldiv_step u_step (
    .mode    (r_op[2]),
    .hi      (r_acc[63:32]),
    .lo      (r_acc[31:0]),
    .opnd    (r_opnd),
    .hi_next (w_hi_next),
    .lo_next (w_lo_next)
  );

  always_comb begin
    w_prod = (r_sign_a ^ r_sign_b) ? (~r_acc + 64'd1) : r_acc;
    w_quo  = (r_sign_a ^ r_sign_b) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    w_rem  = r_sign_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    case (r_op)
      OP_MUL:                       w_fix = w_prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[63:32];
      OP_DIV, OP_DIVU:              w_fix = r_div_zero ? C_ALL_ONES :
                                            (r_div_ovf ? C_INT_MIN : w_quo);
      OP_REM, OP_REMU:              w_fix = r_div_zero ? r_a_raw :
                                            (r_div_ovf ? 32'd0 : w_rem);
      default:                      w_fix = 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_op       <= 3'd0;
      r_rd       <= 5'd0;
      r_opnd     <= 32'd0;
      r_a_raw    <= 32'd0;
      r_acc      <= 64'd0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_div_ovf  <= 1'b0;
      r_result   <= 32'd0;
      r_rd_out   <= 5'd0;
    end else begin
      r_cnt <= (r_state == ST_CALC) ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_op       <= bus.op;
        r_rd       <= bus.rd_in;
        r_a_raw    <= bus.rs1_val;
        r_sign_a   <= w_a_neg;
        r_sign_b   <= w_b_neg;
        r_opnd     <= bus.op[2] ? w_b_mag : w_a_mag;
        r_acc      <= {32'd0, bus.op[2] ? w_a_mag : w_b_mag};
        r_div_zero <= (bus.rs2_val == 32'd0);
        r_div_ovf  <= ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                      (bus.rs1_val == C_INT_MIN) && (bus.rs2_val == C_ALL_ONES);
      end else if (r_state == ST_CALC) begin
        r_acc <= {w_hi_next, w_lo_next};
      end
      if ((r_state == ST_FIX) && !bus.kill) begin
        r_result <= w_fix;
        r_rd_out <= r_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Directed self-checking bench with a cycle-level reference model
// Revision: 1.0
// ============================================================================
module tb_muldiv_unit;

  logic CLK;
  logic rst;
  int   n_checks;
  int   n_fail;

  muldiv_if bus();

  muldiv_unit dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result from plain integer arithmetic
  function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q;
    logic [63:0] ua, ub, p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'b000: begin p = sa * sb;           return p[31:0];  end
      3'b001: begin p = sa * sb;           return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub;           return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Timeline model: one op in flight, result lands 33 edges after acceptance
  int          e_cnt = 0;
  int          m_e0 = 0;
  bit          m_active = 0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rdo = '0;
  bit          m_busy = 0, m_valid = 0;

  always @(posedge CLK) begin
    int  age;
    bit  can_accept;
    e_cnt++;
    age = e_cnt - m_e0;
    if (!rst) begin
      m_active = 0;
      m_res    = '0;
      m_rdo    = '0;
    end else begin
      can_accept = !m_active || (age == 34);
      if (m_active && age == 33 && !bus.kill) begin
        m_res = ref_calc(m_op, m_a, m_b);
        m_rdo = m_rd;
      end
      if (bus.kill || (m_active && age == 34)) m_active = 0;
      if (!bus.kill && bus.start && can_accept) begin
        m_active = 1;
        m_e0 = e_cnt;
        m_op = bus.op;
        m_a  = bus.rs1_val;
        m_b  = bus.rs2_val;
        m_rd = bus.rd_in;
      end
    end
    age     = e_cnt - m_e0;
    m_busy  = m_active && (age <= 32);
    m_valid = m_active && (age == 33);
  end

  always @(negedge CLK) begin
    check("ctl_busy_valid", {30'd0, bus.busy, bus.valid}, {30'd0, m_busy, m_valid});
    check("model_result", bus.result, m_res);
    check("model_rd_out", {27'd0, bus.rd_out}, {27'd0, m_rdo});
  end

  // kind: 0 plain, 1 extra start at cycle 'at', 2 kill at 'at', 3 reset at 'at'
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int kind, input int at);
    int lat;
    int nbusy;
    bit seen;
    bus.start = 1'b1;
    bus.op = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in = rd;
    @(posedge CLK);
    lat = -1;
    nbusy = 0;
    seen = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge CLK);
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      rst       = 1'b1;
      if (kind == 1 && n == at) begin
        bus.start = 1'b1;
        bus.op = 3'b101;
        bus.rs1_val = 32'd1;
        bus.rs2_val = 32'd1;
        bus.rd_in = 5'd9;
      end
      if (kind == 2 && n == at) bus.kill = 1'b1;
      if (kind == 3 && n == at) rst = 1'b0;
      if (kind == 2 && n == at + 1) check("kill_busy", {31'd0, bus.busy}, 32'd0);
      if (kind == 3 && n == at + 1)
        check("rst_outputs", {bus.busy, bus.valid, bus.rd_out, bus.result[24:0]}, 32'd0);
      if (kind == 3 && n == at + 1) check("rst_result", bus.result, 32'd0);
      if (bus.busy) nbusy++;
      if (bus.valid) begin
        seen = 1;
        lat = n;
      end
    end
    if (kind <= 1) begin
      check("latency", lat, 32'd34);
      check("busy_cycles", nbusy, 32'd33);
      check("result", bus.result, exp);
      check("rd_out", {27'd0, bus.rd_out}, {27'd0, rd});
    end else begin
      check("no_valid", {31'd0, seen}, 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.op = 3'd0;
    bus.rs1_val = 32'd0;
    bus.rs2_val = 32'd0;
    bus.rd_in = 5'd0;
    repeat (3) @(negedge CLK);
    check("reset_state", {bus.busy, bus.valid, bus.rd_out, bus.result[24:0]}, 32'd0);
    rst = 1'b1;
    @(negedge CLK);

    run(3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0, 0);
    @(negedge CLK);
    run(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 0, 0);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 0, 0);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 0, 0);
    repeat (2) @(negedge CLK);
    run(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 0, 0);
    run(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 0, 0);
    run(3'b101, 32'd100,       32'd7,         5'd7,  32'd14,        0, 0);
    run(3'b111, 32'd100,       32'd7,         5'd8,  32'd2,         0, 0);
    run(3'b101, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 0, 0);
    run(3'b110, 32'd5,         32'd0,         5'd11, 32'd5,         0, 0);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 0, 0);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         0, 0);
    @(negedge CLK);
    run(3'b101, 32'd1000,      32'd33,        5'd14, 32'd30,        1, 5);
    @(negedge CLK);
    run(3'b100, 32'd50,        32'd5,         5'd15, 32'd10,        2, 10);
    run(3'b111, 32'd50,        32'd7,         5'd16, 32'd1,         3, 20);
    run(3'b000, 32'd3,         32'd4,         5'd17, 32'd12,        0, 0);
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
